// File: rtl/adc_channel_scheduler_pkg.sv
// Shared types and constants for the ADC channel scheduler.
package adc_sched_pkg;
    localparam int unsigned CH_W     = 4;
    localparam int unsigned SAMPLE_W = 10;
    localparam logic [CH_W-1:0] CH_OFF = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WAIT
    } sched_state_t;
endpackage

// File: rtl/adc_channel_scheduler_if.sv
// Channel request / tagged sample link between the scheduler and avr_interface.
interface adc_channel_scheduler_if;
    import adc_sched_pkg::*;

    logic [CH_W-1:0]     channel;
    logic                new_sample;
    logic [SAMPLE_W-1:0] sample;
    logic [CH_W-1:0]     sample_channel;

    modport master (output channel, input new_sample, sample, sample_channel);
    modport slave  (input channel, output new_sample, sample, sample_channel);
endinterface

// File: rtl/adc_channel_scheduler_find_first.sv
// Combinational find-first-set at or above a start index.
module channel_find_first
    import adc_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] vec,
    input  logic [CH_W-1:0]   start,
    output logic              found,
    output logic [CH_W-1:0]   index
);
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && vec[i] && (CH_W'(i) >= start)) begin
                found = 1'b1;
                index = CH_W'(i);
            end
        end
    end
endmodule

// File: rtl/adc_channel_scheduler.sv
// Round-robin ADC channel sequencer with settle-discard, per-channel timeout
// and a per-channel result register file.
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned NUM_CH         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned DISCARD        = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enable,
    input  logic                      start,
    input  logic                      continuous,
    adc_channel_scheduler_if.master   avr,
    output logic                      result_valid,
    output logic [SAMPLE_W-1:0]       result,
    output logic [CH_W-1:0]           result_channel,
    output logic                      timeout,
    output logic                      sweep_done,
    output logic                      busy,
    input  logic [CH_W-1:0]           rd_addr,
    output logic [SAMPLE_W-1:0]       rd_data
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    sched_state_t        state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [1:0]          disc_q, disc_d;
    logic [CH_W-1:0]     channel_q, channel_d;
    logic [SAMPLE_W-1:0] result_d;
    logic [CH_W-1:0]     result_channel_d;
    logic                result_valid_d, timeout_d, sweep_done_d, busy_d;
    logic                wr_en;
    logic                match;
    logic                ff_found;
    logic [CH_W-1:0]     ff_index;
    logic [SAMPLE_W-1:0] results [NUM_CH];

    channel_find_first #(.NUM_CH(NUM_CH)) u_find (
        .vec   (enable),
        .start (idx_q),
        .found (ff_found),
        .index (ff_index)
    );

    assign match       = avr.new_sample && (avr.sample_channel == idx_q);
    assign avr.channel = channel_q;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        to_cnt_d         = to_cnt_q;
        disc_d           = disc_q;
        channel_d        = channel_q;
        result_d         = result;
        result_channel_d = result_channel;
        result_valid_d   = 1'b0;
        timeout_d        = 1'b0;
        sweep_done_d     = 1'b0;
        wr_en            = 1'b0;

        case (state_q)
            IDLE: begin
                channel_d = CH_OFF;
                if (start && (|enable)) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (ff_found) begin
                    state_d   = WAIT;
                    idx_d     = ff_index;
                    channel_d = ff_index;
                    to_cnt_d  = '0;
                    disc_d    = 2'(DISCARD);
                end else begin
                    sweep_done_d = 1'b1;
                    if (continuous && (|enable)) begin
                        state_d = SCAN;
                        idx_d   = '0;
                    end else begin
                        state_d   = IDLE;
                        channel_d = CH_OFF;
                    end
                end
            end
            WAIT: begin
                // Accepting match is tested before the timeout so it wins a tie.
                if (match && (disc_q == 2'd0)) begin
                    wr_en            = 1'b1;
                    result_d         = avr.sample;
                    result_channel_d = idx_q;
                    result_valid_d   = 1'b1;
                    idx_d            = idx_q + 1'b1;
                    state_d          = SCAN;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    idx_d     = idx_q + 1'b1;
                    state_d   = SCAN;
                end else begin
                    if (match) begin
                        disc_d = disc_q - 1'b1;
                    end
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            to_cnt_q       <= '0;
            disc_q         <= '0;
            channel_q      <= CH_OFF;
            result         <= '0;
            result_channel <= '0;
            result_valid   <= 1'b0;
            timeout        <= 1'b0;
            sweep_done     <= 1'b0;
            busy           <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                results[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            to_cnt_q       <= to_cnt_d;
            disc_q         <= disc_d;
            channel_q      <= channel_d;
            result         <= result_d;
            result_channel <= result_channel_d;
            result_valid   <= result_valid_d;
            timeout        <= timeout_d;
            sweep_done     <= sweep_done_d;
            busy           <= busy_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_en && (idx_q == CH_W'(i))) begin
                    results[i] <= avr.sample;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_addr == CH_W'(i)) begin
                rd_data = results[i];
            end
        end
    end
endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed, table-driven bench for adc_channel_scheduler (NUM_CH=8, TIMEOUT_CYCLES=16, DISCARD=1).
module tb_adc_channel_scheduler;
    import adc_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  enable;
    logic        start;
    logic        continuous;
    logic        result_valid;
    logic [9:0]  result;
    logic [3:0]  result_channel;
    logic        timeout;
    logic        sweep_done;
    logic        busy;
    logic [3:0]  rd_addr;
    logic [9:0]  rd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_channel_scheduler_if bus ();

    adc_channel_scheduler #(
        .NUM_CH         (8),
        .TIMEOUT_CYCLES (16),
        .DISCARD        (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .start          (start),
        .continuous     (continuous),
        .avr            (bus.master),
        .result_valid   (result_valid),
        .result         (result),
        .result_channel (result_channel),
        .timeout        (timeout),
        .sweep_done     (sweep_done),
        .busy           (busy),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    typedef struct {
        logic       start;
        logic [7:0] en;
        logic       ns;
        logic [9:0] smp;
        logic [3:0] sc;
        logic [3:0] ra;
        logic [3:0] e_ch;
        logic       e_busy;
        logic       e_rv;
        logic [9:0] e_res;
        logic [3:0] e_rch;
        logic       e_sd;
        logic [9:0] e_rd;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic s, logic [7:0] en, logic ns, logic [9:0] smp, logic [3:0] sc,
                                logic [3:0] ra, logic [3:0] ch, logic b, logic rv, logic [9:0] res,
                                logic [3:0] rch, logic sd, logic [9:0] rd);
        vec_t v;
        v.start = s;  v.en = en;    v.ns = ns;    v.smp = smp;  v.sc = sc;   v.ra = ra;
        v.e_ch = ch;  v.e_busy = b; v.e_rv = rv;  v.e_res = res; v.e_rch = rch;
        v.e_sd = sd;  v.e_rd = rd;
        return v;
    endfunction

    initial begin
        // Basic sweep over ch0/ch2 with one settling sample each.
        tbl[0]  = mk(1, 8'h05, 0, 10'h000, 0, 0, 4'hF, 1, 0, 10'h000, 0, 0, 10'h000);
        tbl[1]  = mk(0, 8'h05, 0, 10'h000, 0, 0, 4'h0, 1, 0, 10'h000, 0, 0, 10'h000);
        tbl[2]  = mk(0, 8'h05, 1, 10'h111, 0, 0, 4'h0, 1, 0, 10'h000, 0, 0, 10'h000);
        tbl[3]  = mk(0, 8'h05, 1, 10'h155, 0, 0, 4'h0, 1, 1, 10'h155, 0, 0, 10'h155);
        tbl[4]  = mk(0, 8'h05, 0, 10'h000, 0, 0, 4'h2, 1, 0, 10'h155, 0, 0, 10'h155);
        tbl[5]  = mk(0, 8'h05, 1, 10'h222, 2, 2, 4'h2, 1, 0, 10'h155, 0, 0, 10'h000);
        tbl[6]  = mk(0, 8'h05, 1, 10'h2AA, 2, 2, 4'h2, 1, 1, 10'h2AA, 2, 0, 10'h2AA);
        tbl[7]  = mk(0, 8'h05, 0, 10'h000, 0, 2, 4'hF, 0, 0, 10'h2AA, 2, 1, 10'h2AA);
        tbl[8]  = mk(0, 8'h05, 0, 10'h000, 0, 9, 4'hF, 0, 0, 10'h2AA, 2, 0, 10'h000);
        // start with nothing enabled stays idle
        tbl[9]  = mk(1, 8'h00, 0, 10'h000, 0, 0, 4'hF, 0, 0, 10'h2AA, 2, 0, 10'h155);
        // Mismatch filtering on ch2
        tbl[10] = mk(1, 8'h04, 0, 10'h000, 0, 2, 4'hF, 1, 0, 10'h2AA, 2, 0, 10'h2AA);
        tbl[11] = mk(0, 8'h04, 0, 10'h000, 0, 2, 4'h2, 1, 0, 10'h2AA, 2, 0, 10'h2AA);
        tbl[12] = mk(0, 8'h04, 1, 10'h3FF, 3, 2, 4'h2, 1, 0, 10'h2AA, 2, 0, 10'h2AA);
        tbl[13] = mk(0, 8'h04, 1, 10'h123, 2, 2, 4'h2, 1, 0, 10'h2AA, 2, 0, 10'h2AA);
        tbl[14] = mk(0, 8'h04, 1, 10'h3FF, 3, 3, 4'h2, 1, 0, 10'h2AA, 2, 0, 10'h000);
        tbl[15] = mk(0, 8'h04, 1, 10'h0AB, 2, 2, 4'h2, 1, 1, 10'h0AB, 2, 0, 10'h0AB);
        tbl[16] = mk(0, 8'h04, 0, 10'h000, 0, 2, 4'hF, 0, 0, 10'h0AB, 2, 1, 10'h0AB);
        tbl[17] = mk(0, 8'h04, 0, 10'h000, 0, 0, 4'hF, 0, 0, 10'h0AB, 2, 0, 10'h155);

        rst = 1'b1; enable = '0; start = 1'b0; continuous = 1'b0; rd_addr = '0;
        bus.new_sample = 1'b0; bus.sample = '0; bus.sample_channel = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset channel", bus.channel, 4'hF);
        chk("reset busy", busy, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset result", result, 0);
        chk("reset result_channel", result_channel, 0);
        chk("reset rd_data", rd_data, 0);

        for (int i = 0; i < 18; i++) begin
            start = tbl[i].start; enable = tbl[i].en; rd_addr = tbl[i].ra;
            bus.new_sample = tbl[i].ns; bus.sample = tbl[i].smp; bus.sample_channel = tbl[i].sc;
            tick();
            chk($sformatf("row%0d channel", i), bus.channel, tbl[i].e_ch);
            chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("row%0d result_valid", i), result_valid, tbl[i].e_rv);
            chk($sformatf("row%0d result", i), result, tbl[i].e_res);
            chk($sformatf("row%0d result_channel", i), result_channel, tbl[i].e_rch);
            chk($sformatf("row%0d timeout", i), timeout, 0);
            chk($sformatf("row%0d sweep_done", i), sweep_done, tbl[i].e_sd);
            chk($sformatf("row%0d rd_data", i), rd_data, tbl[i].e_rd);
        end
        bus.new_sample = 1'b0; start = 1'b0;

        // Timeout on ch1 with no samples
        enable = 8'h02; start = 1'b1;
        tick();
        start = 1'b0;
        chk("to busy", busy, 1);
        tick();
        chk("to channel", bus.channel, 4'h1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                chk($sformatf("to early k%0d", k), timeout, 0);
            end else begin
                chk("to pulse", timeout, 1);
                chk("to busy in scan", busy, 1);
                chk("to no result", result_valid, 0);
            end
        end
        tick();
        chk("to sweep_done", sweep_done, 1);
        chk("to timeout cleared", timeout, 0);
        chk("to busy end", busy, 0);
        rd_addr = 4'd1;
        #1;
        chk("to results1", rd_data, 0);

        // Accepting match on the last timeout cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("sim channel", bus.channel, 4'h1);
        for (int k = 1; k <= 16; k++) begin
            bus.new_sample = (k == 1 || k == 16);
            bus.sample = (k == 1) ? 10'h001 : 10'h3C3;
            bus.sample_channel = 4'h1;
            tick();
            if (k < 16) begin
                chk($sformatf("sim rv k%0d", k), result_valid, 0);
                chk($sformatf("sim to k%0d", k), timeout, 0);
            end else begin
                chk("sim rv last", result_valid, 1);
                chk("sim to last", timeout, 0);
                chk("sim result", result, 10'h3C3);
                chk("sim result_channel", result_channel, 1);
            end
        end
        bus.new_sample = 1'b0;
        tick();
        chk("sim sweep_done", sweep_done, 1);
        chk("sim no late timeout", timeout, 0);
        chk("sim rd_data", rd_data, 10'h3C3);

        // Continuous sweeps on ch7, continuous dropped during the third
        enable = 8'h80; continuous = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("cont busy", busy, 1);
        tick();
        chk("cont channel", bus.channel, 4'h7);
        for (int r = 0; r < 3; r++) begin
            bus.new_sample = 1'b1; bus.sample_channel = 4'h7; bus.sample = 10'(10'h100 + r);
            if (r == 2) continuous = 1'b0;
            tick();
            chk($sformatf("cont r%0d discard", r), result_valid, 0);
            bus.sample = 10'(10'h200 + r);
            tick();
            chk($sformatf("cont r%0d rv", r), result_valid, 1);
            chk($sformatf("cont r%0d result", r), result, 10'(10'h200 + r));
            bus.new_sample = 1'b0;
            tick();
            chk($sformatf("cont r%0d sweep_done", r), sweep_done, 1);
            if (r < 2) begin
                chk($sformatf("cont r%0d busy", r), busy, 1);
                tick();
                chk($sformatf("cont r%0d rewait ch", r), bus.channel, 4'h7);
                chk($sformatf("cont r%0d rewait busy", r), busy, 1);
            end else begin
                chk("cont stop busy", busy, 0);
                chk("cont stop channel", bus.channel, 4'hF);
            end
        end

        // Reset during WAIT, with an ignored start while busy
        enable = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rw channel", bus.channel, 4'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rw start ignored ch", bus.channel, 4'h0);
        chk("rw start ignored busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw busy", busy, 0);
        chk("rw channel off", bus.channel, 4'hF);
        chk("rw result", result, 0);
        chk("rw result_channel", result_channel, 0);
        chk("rw result_valid", result_valid, 0);
        chk("rw sweep_done", sweep_done, 0);
        chk("rw timeout", timeout, 0);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            chk($sformatf("rw rd_data a%0d", a), rd_data, 0);
        end
        tick();
        chk("rw stays idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_channel_scheduler.md
# adc_channel_scheduler

- Sequences the AVR ADC sampling path by driving `avr_interface`'s `channel` input.
- Walks round-robin over a mask of enabled analog channels and waits on each channel for a sample tagged with that channel.
- Discards settling samples, and times out if a channel never responds.
- Keeps the latest 10-bit value per channel in a register file, which user logic reads. Sits between `avr_interface` and user logic.

## Interface

Parameters:
- `NUM_CH`, 8: channels scanned, 1..15. Channel 15 is reserved as "sampling off".
- `TIMEOUT_CYCLES`, 50000: maximum cycles spent in WAIT per channel. Must be ≥2.
- `DISCARD`, 1: matching samples dropped after each channel switch before one is accepted. Range 0..3.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in NUM_CH: per-channel scan enable, sampled live at every SCAN.
- `start` in 1: one-cycle pulse; begins a sweep when idle.
- `continuous` in 1: 1 = restart the sweep after completion.
- `channel` out 4: channel request to `avr_interface`.
- `new_sample` in 1: sample strobe from `avr_interface`.
- `sample` in 10: sample value.
- `sample_channel` in 4: channel tag of the sample.
- `result_valid` out 1: one-cycle pulse, a new result was stored.
- `result` out 10: accepted sample value.
- `result_channel` out 4: channel of `result`.
- `timeout` out 1: one-cycle pulse, a channel timed out.
- `sweep_done` out 1: one-cycle pulse at the end of each sweep.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `rd_addr` in 4: result-file read address.
- `rd_data` out 10: combinational read of `results[rd_addr]`. Returns 0 if `rd_addr` ≥ NUM_CH.

## Operation

- States: IDLE, SCAN, WAIT.
- **IDLE**
  - `channel` = 4'hF.
  - `start` = 1 and `enable` ≠ 0 → SCAN with `idx` = 0.
  - `start` with `enable` = 0 is ignored.
- **SCAN**
  - Find the lowest enabled channel ≥ `idx`.
  - Found `c` → WAIT: `idx` = `c`, `channel` = `c`, timeout counter = 0, discard counter = DISCARD.
  - None found → `sweep_done` pulse.
    - If `continuous` = 1 and `enable` ≠ 0: SCAN with `idx` = 0.
    - Otherwise: IDLE.
- **WAIT**
  - A "match" is `new_sample` = 1 and `sample_channel` == `idx`.
  - Samples from other channels are ignored, and do not affect the counters.
  - Match with discard counter > 0: decrement the discard counter and stay in WAIT.
  - Match with discard counter = 0:
    - `results[idx]` ← `sample`.
    - `result`/`result_channel` ← `sample`/`idx`, with a `result_valid` pulse.
    - `idx` + 1 → SCAN.
  - Timeout counter == TIMEOUT_CYCLES−1 with no accepted match: `timeout` pulse, `results[idx]` unchanged, `idx` + 1 → SCAN.
  - An accepting match and a timeout in the same cycle: the match wins and no timeout is raised.
  - `idx` = NUM_CH−1 incremented gives NUM_CH. The next SCAN then finds nothing and ends the sweep; there is no wrap within a sweep.
- `start` while `busy` = 1 is ignored.
- `continuous` deasserted mid-sweep: the current sweep completes, then the FSM returns to IDLE.
- `enable` bit cleared mid-sweep: that channel is skipped at the next SCAN, but a WAIT already in progress completes.
- `rst` (any state, including mid-WAIT) gives:
  - IDLE, `idx` = 0;
  - `channel` = 4'hF;
  - all pulses 0, `busy` = 0;
  - `result` = 0, `result_channel` = 0;
  - all `results` = 0;
  - both counters = 0.

## Timing

- All outputs are registered except `rd_data`.
- `start` in cycle N (IDLE) → `busy` = 1 and SCAN in N+1 → WAIT in N+2, with `channel` valid from N+2.
- Accepting match in cycle M → `result_valid`, `result`, `result_channel` and `results[idx]` updated in M+1. `rd_data` reflects the new value in M+1. The FSM is in SCAN in M+1.
- WAIT entered in cycle W with no matches → `timeout` = 1 in W+TIMEOUT_CYCLES, with the FSM in SCAN.
- Empty SCAN in cycle K → `sweep_done` = 1 in K+1.
  - Non-continuous: `busy` = 0 and `channel` = 4'hF in K+1.
- Minimum per-channel cost: 2 cycles + sample latency.
- Timeout counter width: $clog2(TIMEOUT_CYCLES).

## Structure

- Package `adc_sched_pkg` holds:
  - the state enum (IDLE, SCAN, WAIT);
  - `CH_OFF` = 4'hF;
  - `CH_W` = 4;
  - `SAMPLE_W` = 10.
- Sub-module `channel_find_first`: combinational find-first-set at or above a start index over NUM_CH bits. Outputs `found` and `index`.
- Results storage: NUM_CH×10 register array in the top module.

## Test plan

- **Basic sweep:** `enable` = 8'b0000_0101, DISCARD = 1, `start`. Stub returns two samples per channel (0x111 then 0x155 for ch0; 0x222 then 0x2AA for ch2).
  - Required: `result_valid` twice, with 0x155/ch0 then 0x2AA/ch2; then `sweep_done`; `busy` = 0, `channel` = 0xF.
- **Mismatch filtering:** in WAIT on ch2, inject `sample_channel` = 3 with 0x3FF.
  - Required: no result. The following ch2 sample 0x0AB is stored, and `rd_addr` = 2 reads 0x0AB.
- **Timeout:** TIMEOUT_CYCLES = 16, `enable` = 8'b0000_0010, no samples.
  - Required: `timeout` exactly 16 cycles after WAIT entry, then `sweep_done`; `results[1]` stays 0.
- **Simultaneous:** accepting match on the last timeout cycle.
  - Required: `result_valid` = 1 and `timeout` = 0.
- **Continuous:** `continuous` = 1 with `enable` = 8'h80.
  - Required: `sweep_done` after each ch7 result, and `busy` stays 1.
  - Deassert `continuous`: the FSM returns to IDLE after the next `sweep_done`.
- **Reset mid-WAIT:** assert `rst` one cycle during WAIT.
  - Required: next cycle IDLE, `channel` = 0xF, `rd_data` = 0 for all addresses.
  - A `start` issued during `busy` is ignored.
